// File: rtl/tb_dinb_map_pkg.sv
// Shared codes for the temp-buffer port-B write and read mappers:
// source/direction select fields and the mapper FSM encoding.
package tb_dinb_map_pkg;

  localparam int unsigned SEL_W = 3;

  localparam logic TB_B      = 1'b0;
  localparam logic TB_B_CONS = 1'b1;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_POS  = 2'b01,
    DIR_NEG  = 2'b10,
    DIR_NEW  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Write-back select as presented on TB_dinb_sel: {source, direction}.
  typedef struct packed {
    logic       src;
    logic [1:0] dir;
  } sel_t;

endpackage

// File: rtl/tb_lane_reverse.sv
// Lane permutation for write-back: identity (POS) or lane-reversed (NEG).
module tb_lane_reverse #(
  parameter int unsigned X      = 4,
  parameter int unsigned RSA_DW = 16
) (
  input  logic [X*RSA_DW-1:0] din,
  input  logic                rev,
  output logic [X*RSA_DW-1:0] dout_c
);

  always_comb begin
    dout_c = din;
    if (rev) begin
      for (int unsigned i = 0; i < X; i++) begin
        dout_c[i*RSA_DW +: RSA_DW] = din[(X-1-i)*RSA_DW +: RSA_DW];
      end
    end
  end

endmodule

// File: rtl/tb_dinb_map.sv
// Temp-buffer port-B write mapper: bursts RSA or CONS result vectors into
// consecutive temp-buffer addresses with optional lane reversal.
module tb_dinb_map
  import tb_dinb_map_pkg::*;
#(
  parameter int unsigned X      = 4,
  parameter int unsigned L      = 4,
  parameter int unsigned RSA_DW = 16,
  parameter int unsigned TB_AW  = 10,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                clk,
  input  logic                sys_rst,
  input  logic [SEL_W-1:0]    TB_dinb_sel,
  input  logic                start,
  input  logic [TB_AW-1:0]    base_addr,
  input  logic [LEN_W-1:0]    len,
  input  logic [X*RSA_DW-1:0] C_dout,
  input  logic                C_dout_valid,
  input  logic [X*RSA_DW-1:0] CONS_dout,
  input  logic                CONS_dout_valid,
  output logic [L*RSA_DW-1:0] TB_dinb,
  output logic [TB_AW-1:0]    TB_addrb,
  output logic                TB_enb,
  output logic                TB_web,
  output logic                busy,
  output logic                done
);

  localparam int unsigned DW_X = X * RSA_DW;
  localparam int unsigned DW_L = L * RSA_DW;

  state_e            state_q, state_d;
  sel_t              sel_q, sel_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [TB_AW-1:0]  addr_q, addr_d;
  logic [DW_L-1:0]   dinb_q, dinb_d;
  logic [TB_AW-1:0]  addrb_q, addrb_d;
  logic              enb_q, enb_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  sel_t              sel_in_c;
  logic              skip_c;
  logic [DW_X-1:0]   src_c;
  logic [DW_X-1:0]   perm_c;
  logic              src_vld_c;
  logic              accept_c;
  logic              last_c;

  assign sel_in_c  = sel_t'(TB_dinb_sel);
  // Bursts that can never write go straight to DONE.
  assign skip_c    = (len == '0) || (sel_in_c.dir == DIR_IDLE) || (sel_in_c.dir == DIR_NEW);
  assign src_c     = (sel_q.src == TB_B_CONS) ? CONS_dout : C_dout;
  assign src_vld_c = (sel_q.src == TB_B_CONS) ? CONS_dout_valid : C_dout_valid;
  assign accept_c  = (state_q == ST_RUN) && src_vld_c;
  assign last_c    = (LEN_W'(cnt_q + 1'b1) == len_q);

  tb_lane_reverse #(
    .X      (X),
    .RSA_DW (RSA_DW)
  ) u_lane_reverse (
    .din    (src_c),
    .rev    (sel_q.dir == DIR_NEG),
    .dout_c (perm_c)
  );

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = skip_c ? ST_DONE : ST_RUN;
      ST_RUN:  if (accept_c && last_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Configuration latch, beat counting and next values of the port-B outputs.
  always_comb begin
    sel_d   = sel_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dinb_d  = '0;
    addrb_d = addrb_q;
    enb_d   = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    if ((state_q == ST_IDLE) && start) begin
      sel_d  = sel_in_c;
      len_d  = len;
      cnt_d  = '0;
      addr_d = base_addr;
    end
    if (accept_c) begin
      dinb_d  = DW_L'(perm_c);
      addrb_d = addr_q;
      enb_d   = 1'b1;
      cnt_d   = LEN_W'(cnt_q + 1'b1);
      addr_d  = TB_AW'(addr_q + 1'b1);
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      sel_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      dinb_q  <= '0;
      addrb_q <= '0;
      enb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dinb_q  <= dinb_d;
      addrb_q <= addrb_d;
      enb_q   <= enb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign TB_dinb  = dinb_q;
  assign TB_addrb = addrb_q;
  assign TB_enb   = enb_q;
  assign TB_web   = enb_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tb_dinb_map.sv
// Scoreboard bench for tb_dinb_map: expected writes are queued as beats are
// driven and matched against port-B writes seen on the falling clock edge.
module tb_tb_dinb_map;

  localparam int unsigned X  = 4;
  localparam int unsigned L  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 10;
  localparam int unsigned LW = 8;

  logic            clk = 1'b0;
  logic            sys_rst;
  logic [2:0]      TB_dinb_sel;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [LW-1:0]   len;
  logic [X*DW-1:0] C_dout;
  logic            C_dout_valid;
  logic [X*DW-1:0] CONS_dout;
  logic            CONS_dout_valid;
  logic [L*DW-1:0] TB_dinb;
  logic [AW-1:0]   TB_addrb;
  logic            TB_enb;
  logic            TB_web;
  logic            busy;
  logic            done;

  tb_dinb_map #(
    .X(X), .L(L), .RSA_DW(DW), .TB_AW(AW), .LEN_W(LW)
  ) dut (
    .clk             (clk),
    .sys_rst         (sys_rst),
    .TB_dinb_sel     (TB_dinb_sel),
    .start           (start),
    .base_addr       (base_addr),
    .len             (len),
    .C_dout          (C_dout),
    .C_dout_valid    (C_dout_valid),
    .CONS_dout       (CONS_dout),
    .CONS_dout_valid (CONS_dout_valid),
    .TB_dinb         (TB_dinb),
    .TB_addrb        (TB_addrb),
    .TB_enb          (TB_enb),
    .TB_web          (TB_web),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [L*DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int n_checks   = 0;
  int n_pass     = 0;
  int done_seen  = 0;
  int done_exp   = 0;
  int writes_seen = 0;
  int exp_writes = 0;

  // Bench-side model of the burst in flight.
  logic [2:0]    m_sel;
  logic [AW-1:0] m_base;
  logic [LW-1:0] m_len;
  logic [LW-1:0] m_k;
  logic          m_active = 1'b0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [L*DW-1:0] model_map(input logic [1:0] dir, input logic [X*DW-1:0] src);
    logic [L*DW-1:0] r;
    r = '0;
    for (int i = 0; i < X; i++) begin
      if (dir == 2'b10) r[i*DW +: DW] = src[(X-1-i)*DW +: DW];
      else              r[i*DW +: DW] = src[i*DW +: DW];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [2:0] s, input logic [AW-1:0] b, input logic [LW-1:0] n);
    TB_dinb_sel = s;
    base_addr   = b;
    len         = n;
    start       = 1'b1;
    m_sel       = s;
    m_base      = b;
    m_len       = n;
    m_k         = '0;
    m_active    = (n != '0) && ((s[1:0] == 2'b01) || (s[1:0] == 2'b10));
    tick();
    start = 1'b0;
    if (!m_active) begin
      done_exp++;
      chk_eq("skip_done", 64'(done), 64'd1);
      chk_eq("skip_busy", 64'(busy), 64'd1);
    end else begin
      chk_eq("run_busy", 64'(busy), 64'd1);
      chk_eq("run_no_done", 64'(done), 64'd0);
    end
  endtask

  task automatic beat(input logic cv, input logic [63:0] cd, input logic nv, input logic [63:0] nd);
    logic sv;
    logic last;
    C_dout          = cd;
    C_dout_valid    = cv;
    CONS_dout       = nd;
    CONS_dout_valid = nv;
    sv   = m_sel[2] ? nv : cv;
    last = 1'b0;
    if (m_active && sv) begin
      sb_q.push_back('{addr: AW'(m_base + AW'(m_k)),
                       data: model_map(m_sel[1:0], m_sel[2] ? nd : cd)});
      exp_writes++;
      m_k = LW'(m_k + 1'b1);
      if (m_k == m_len) begin
        m_active = 1'b0;
        last     = 1'b1;
      end
    end
    tick();
    if (last) begin
      done_exp++;
      chk_eq("done_pulse", 64'(done), 64'd1);
      chk_eq("busy_in_done", 64'(busy), 64'd1);
    end
    C_dout_valid    = 1'b0;
    CONS_dout_valid = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Write monitor: every enabled cycle must match the next expected write.
  always @(negedge clk) begin
    if (TB_enb) begin
      writes_seen++;
      if (sb_q.size() == 0) begin
        chk_eq("unexpected_write", 64'(TB_enb), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk_eq("web", 64'(TB_web), 64'd1);
        chk_eq("addr", 64'(TB_addrb), 64'(mon_e.addr));
        chk_eq("data", TB_dinb, mon_e.data);
      end
    end else begin
      chk_eq("idle_web", 64'(TB_web), 64'd0);
      chk_eq("idle_dinb", TB_dinb, 64'd0);
    end
    if (done) done_seen++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] d;
    sys_rst         = 1'b1;
    TB_dinb_sel     = '0;
    start           = 1'b0;
    base_addr       = '0;
    len             = '0;
    C_dout          = '0;
    C_dout_valid    = 1'b0;
    CONS_dout       = '0;
    CONS_dout_valid = 1'b0;
    tick();
    tick();
    chk_eq("rst_enb", 64'(TB_enb), 64'd0);
    chk_eq("rst_dinb", TB_dinb, 64'd0);
    chk_eq("rst_addrb", 64'(TB_addrb), 64'd0);
    chk_eq("rst_busy", 64'(busy), 64'd0);
    chk_eq("rst_done", 64'(done), 64'd0);
    sys_rst = 1'b0;
    tick();

    // POS burst from C, three back-to-back beats.
    start_burst(3'b001, 10'h010, 8'd3);
    d = {16'd3, 16'd2, 16'd1, 16'd0};
    beat(1'b1, d, 1'b0, '0);
    chk_eq("pos_lane_literal", TB_dinb, 64'h0003_0002_0001_0000);
    beat(1'b1, d + 64'h0010_0010_0010_0010, 1'b0, rnd64());
    beat(1'b1, rnd64(), 1'b1, rnd64());
    // start arriving during DONE must be dropped.
    TB_dinb_sel = 3'b001;
    base_addr   = 10'h200;
    len         = 8'd3;
    start       = 1'b1;
    tick();
    start = 1'b0;
    chk_eq("start_in_done_busy", 64'(busy), 64'd0);
    chk_eq("start_in_done_done", 64'(done), 64'd0);
    tick();
    chk_eq("idle_after_done", 64'(busy), 64'd0);

    // NEG burst from CONS; C valid alone writes nothing, start mid-burst ignored.
    start_burst(3'b110, 10'h100, 8'd2);
    d = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    beat(1'b0, '0, 1'b1, d);
    chk_eq("neg_lane_literal", TB_dinb, 64'h000A_000B_000C_000D);
    beat(1'b1, rnd64(), 1'b0, rnd64());
    TB_dinb_sel = 3'b001;
    base_addr   = 10'h155;
    len         = 8'd1;
    start       = 1'b1;
    beat(1'b1, rnd64(), 1'b0, rnd64());
    start = 1'b0;
    beat(1'b1, rnd64(), 1'b1, rnd64());
    tick();
    tick();

    // Address wrap with a gap in valid.
    start_burst(3'b001, 10'h3FE, 8'd4);
    beat(1'b1, rnd64(), 1'b0, '0);
    beat(1'b0, rnd64(), 1'b1, rnd64());
    beat(1'b1, rnd64(), 1'b0, '0);
    beat(1'b1, rnd64(), 1'b0, '0);
    beat(1'b1, rnd64(), 1'b0, '0);
    tick();
    tick();

    // Degenerate bursts: zero length and NEW direction.
    start_burst(3'b001, 10'h040, 8'd0);
    tick();
    chk_eq("len0_done_clear", 64'(done), 64'd0);
    chk_eq("len0_busy_clear", 64'(busy), 64'd0);
    start_burst(3'b011, 10'h040, 8'd5);
    beat(1'b1, rnd64(), 1'b0, '0);
    chk_eq("new_busy_clear", 64'(busy), 64'd0);
    tick();

    // Reset in the middle of a burst.
    start_burst(3'b001, 10'h020, 8'd5);
    beat(1'b1, rnd64(), 1'b0, '0);
    beat(1'b1, rnd64(), 1'b0, '0);
    @(negedge clk);
    #1;
    sys_rst = 1'b1;
    m_active = 1'b0;
    #1;
    chk_eq("arst_enb", 64'(TB_enb), 64'd0);
    chk_eq("arst_web", 64'(TB_web), 64'd0);
    chk_eq("arst_dinb", TB_dinb, 64'd0);
    chk_eq("arst_addrb", 64'(TB_addrb), 64'd0);
    chk_eq("arst_busy", 64'(busy), 64'd0);
    chk_eq("arst_done", 64'(done), 64'd0);
    C_dout_valid = 1'b1;
    C_dout       = rnd64();
    tick();
    tick();
    sys_rst = 1'b0;
    tick();
    tick();
    chk_eq("post_rst_busy", 64'(busy), 64'd0);
    C_dout_valid = 1'b0;
    start_burst(3'b101, 10'h0A0, 8'd2);
    beat(1'b1, rnd64(), 1'b1, rnd64());
    beat(1'b0, rnd64(), 1'b1, rnd64());
    tick();
    tick();

    chk_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    chk_eq("write_count", 64'(writes_seen), 64'(exp_writes));
    chk_eq("done_count", 64'(done_seen), 64'(done_exp));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
